// File: rtl/seq_mult_taint_hs.sv
// seq_mult_taint_hs: shift-add sequential multiplier with valid/ready handshake,
// optional two's-complement mode and conservative bit-level taint tracking.
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   in_valid / in_ready              operand handshake (accepts in IDLE only)
//   multiplier, multiplier_t         operand A and its taint
//   multiplicand, multiplicand_t     operand B and its taint
//   out_valid / out_ready            result handshake (held until accepted)
//   product, product_t               2*WIDTH result and its taint (0 unless DONE)
//   busy                             high while RUN or DONE
module seq_mult_taint_hs #(
  parameter int unsigned WIDTH  = 4,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplier_t,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplicand_t,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [2*WIDTH-1:0]   product_t,
  output logic                 busy
);

  localparam int unsigned HW = WIDTH + 1;       // hi half incl. carry/sign bit
  localparam int unsigned PW = 2 * WIDTH + 1;   // full shift register
  localparam int unsigned RW = 2 * WIDTH;       // product width
  localparam int unsigned CW = $clog2(WIDTH);   // step counter

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     p_q, p_d, pt_q, pt_d;
  logic [WIDTH-1:0]  md_q, md_d, mdt_q, mdt_d;

  logic              in_ready_d, out_valid_d, busy_d;
  logic [RW-1:0]     product_d, product_t_d;

  // Conservative carry/borrow spread: a tainted bit may affect every bit above it.
  function automatic logic [HW-1:0] smear(input logic [HW-1:0] x);
    logic [HW-1:0] r;
    logic          acc;
    acc = 1'b0;
    for (int unsigned i = 0; i < HW; i++) begin
      acc  = acc | x[i];
      r[i] = acc;
    end
    return r;
  endfunction

  // One shift-add step on the value and taint registers.
  logic [HW-1:0]     hi, hi_t, md_ext, mdt_ext, add_term, at, hi_new, hit_new;
  logic [WIDTH-1:0]  lo, lo_t;
  logic              last_step, sx, sx_t;
  logic [PW-1:0]     p_step, pt_step;

  always_comb begin
    hi        = p_q[PW-1:WIDTH];
    lo        = p_q[WIDTH-1:0];
    hi_t      = pt_q[PW-1:WIDTH];
    lo_t      = pt_q[WIDTH-1:0];
    last_step = (count_q == CW'(WIDTH - 1));
    md_ext    = SIGNED ? {md_q[WIDTH-1], md_q}   : {1'b0, md_q};
    mdt_ext   = SIGNED ? {mdt_q[WIDTH-1], mdt_q} : {1'b0, mdt_q};
    add_term  = p_q[0] ? md_ext : '0;
    // Two's-complement: the multiplier MSB has negative weight, so the last step subtracts.
    hi_new    = (SIGNED && last_step) ? (hi - add_term) : (hi + add_term);
    sx        = SIGNED ? hi_new[WIDTH] : 1'b0;
    p_step    = {sx, hi_new, lo[WIDTH-1:1]};

    // A tainted multiplier bit may select any add term, so it taints the whole sum.
    at        = pt_q[0] ? '1 : (p_q[0] ? mdt_ext : '0);
    hit_new   = (pt_q[0] | p_q[0]) ? smear(hi_t | at) : hi_t;
    sx_t      = SIGNED ? hit_new[WIDTH] : 1'b0;
    pt_step   = {sx_t, hit_new, lo_t[WIDTH-1:1]};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    p_d         = p_q;
    pt_d        = pt_q;
    md_d        = md_q;
    mdt_d       = mdt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          p_d     = {HW'(0), multiplier};
          pt_d    = {HW'(0), multiplier_t};
          md_d    = multiplicand;
          mdt_d   = multiplicand_t;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d     = p_step;
        pt_d    = pt_step;
        count_d = count_q + CW'(1);
        if (last_step) begin
          count_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          p_d     = '0;
          pt_d    = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
    product_d   = out_valid_d ? p_d[RW-1:0]  : '0;
    product_t_d = out_valid_d ? pt_d[RW-1:0] : '0;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      p_q       <= '0;
      pt_q      <= '0;
      md_q      <= '0;
      mdt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      product_t <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      p_q       <= p_d;
      pt_q      <= pt_d;
      md_q      <= md_d;
      mdt_q     <= mdt_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      product   <= product_d;
      product_t <= product_t_d;
    end
  end

endmodule

// File: tb/tb_seq_mult_taint_hs.sv
// tb_seq_mult_taint_hs: drives four multiplier instances (W=4/8, unsigned/signed)
// with directed and random operations; checks products against integer arithmetic
// and taints against literal values and a flip-based superset property.
module tb_seq_mult_taint_hs;

  localparam int NDUT = 4;

  logic clk;
  logic rst_n;
  logic       in_valid  [NDUT];
  logic       out_ready [NDUT];
  logic [7:0] mplr      [NDUT];
  logic [7:0] mplr_t    [NDUT];
  logic [7:0] mcnd      [NDUT];
  logic [7:0] mcnd_t    [NDUT];
  logic       in_ready  [NDUT];
  logic       out_valid [NDUT];
  logic       busy      [NDUT];
  logic [15:0] prod     [NDUT];
  logic [15:0] prod_t   [NDUT];

  logic [15:0] exp_p    [NDUT];
  logic [15:0] exp_t    [NDUT];
  bit          exp_t_en [NDUT];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance g: WIDTH = 4 for g<2 else 8; SIGNED = odd g.
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned W = (g < 2) ? 4 : 8;
    localparam bit          S = ((g % 2) == 1);
    logic [2*W-1:0] p, pt;
    seq_mult_taint_hs #(.WIDTH(W), .SIGNED(S)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid[g]),
      .in_ready       (in_ready[g]),
      .multiplier     (mplr[g][W-1:0]),
      .multiplier_t   (mplr_t[g][W-1:0]),
      .multiplicand   (mcnd[g][W-1:0]),
      .multiplicand_t (mcnd_t[g][W-1:0]),
      .out_valid      (out_valid[g]),
      .out_ready      (out_ready[g]),
      .product        (p),
      .product_t      (pt),
      .busy           (busy[g])
    );
    assign prod[g]   = 16'(p);
    assign prod_t[g] = 16'(pt);
  end

  function automatic int wid(input int k);
    return (k < 2) ? 4 : 8;
  endfunction

  function automatic bit sgn(input int k);
    return (k % 2) == 1;
  endfunction

  function automatic logic [7:0] wmask(input int k);
    return (k < 2) ? 8'h0F : 8'hFF;
  endfunction

  // Reference product: plain integer multiply, truncated to 2*W bits.
  function automatic logic [15:0] model(input int k, input logic [7:0] a, input logic [7:0] b);
    int     w;
    longint sa, sb, m;
    w  = wid(k);
    m  = (longint'(1) << w) - 1;
    sa = longint'(a) & m;
    sb = longint'(b) & m;
    if (sgn(k)) begin
      if (((sa >> (w - 1)) & 1) != 0) sa = sa - (longint'(1) << w);
      if (((sb >> (w - 1)) & 1) != 0) sb = sb - (longint'(1) << w);
    end
    return 16'((sa * sb) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic check(input int k, input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[dut%0d]: got %h, expected %h at %0t", name, k, got, want, $time);
    end
  endtask

  // Every cycle: idle outputs read zero, DONE exposes the expected product.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      check(k, "mon_in_ready_vs_busy", 16'(in_ready[k]), 16'(!busy[k]));
      if (out_valid[k] === 1'b1) begin
        check(k, "mon_product", prod[k], exp_p[k]);
        if (exp_t_en[k]) check(k, "mon_product_t", prod_t[k], exp_t[k]);
        check(k, "mon_in_ready_in_done", 16'(in_ready[k]), 16'(0));
      end else begin
        check(k, "mon_idle_product", prod[k], 16'h0);
        check(k, "mon_idle_product_t", prod_t[k], 16'h0);
      end
    end
  end

  // Full operation: accept, latency, optional backpressure, release.
  task automatic do_op(input int k, input logic [7:0] a, input logic [7:0] at,
                       input logic [7:0] b, input logic [7:0] bt, input int stall,
                       output logic [15:0] gp, output logic [15:0] gt);
    int n;
    exp_p[k] = model(k, a, b);
    n = 0;
    while (in_ready[k] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check(k, "in_ready_wait", 16'(in_ready[k]), 16'(1));
    mplr[k] = a; mplr_t[k] = at; mcnd[k] = b; mcnd_t[k] = bt;
    in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    mplr[k]   = 8'($urandom) & wmask(k);
    mplr_t[k] = 8'($urandom) & wmask(k);
    mcnd[k]   = 8'($urandom) & wmask(k);
    mcnd_t[k] = 8'($urandom) & wmask(k);
    n = 0;
    while (out_valid[k] !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check(k, "latency", 16'(n), 16'(wid(k)));
    gp = prod[k];
    gt = prod_t[k];
    repeat (stall) begin
      in_valid[k] = 1'b1;
      mplr[k] = 8'($urandom) & wmask(k);
      @(posedge clk); #1;
      check(k, "hold_out_valid", 16'(out_valid[k]), 16'(1));
      check(k, "hold_product", prod[k], gp);
      check(k, "hold_product_t", prod_t[k], gt);
      check(k, "hold_in_ready", 16'(in_ready[k]), 16'(0));
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    check(k, "release_idle", 16'({out_valid[k], in_ready[k]}), 16'(2'b01));
  endtask

  initial begin
    logic [15:0] gp, gt, changed;
    logic [7:0]  a, b, at, bt, a2, b2;
    int n;

    rst_n = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0;
      mplr[k] = '0; mplr_t[k] = '0; mcnd[k] = '0; mcnd_t[k] = '0;
      exp_p[k] = '0; exp_t[k] = '0; exp_t_en[k] = 1'b0;
    end

    // Pin the reference model with hand-computed values.
    check(0, "model_7x13", model(0, 8'd7, 8'd13), 16'h005B);
    check(1, "model_m3x5", model(1, 8'h0D, 8'h05), 16'h00F1);
    check(1, "model_m8xm8", model(1, 8'h08, 8'h08), 16'h0040);
    check(2, "model_255x255", model(2, 8'hFF, 8'hFF), 16'hFE01);
    check(3, "model_m128xm128", model(3, 8'h80, 8'h80), 16'h4000);

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check(k, "reset_in_ready", 16'(in_ready[k]), 16'(1));
      check(k, "reset_out_valid", 16'(out_valid[k]), 16'(0));
      check(k, "reset_busy", 16'(busy[k]), 16'(0));
      check(k, "reset_product", prod[k], 16'h0);
      check(k, "reset_product_t", prod_t[k], 16'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned basic product, clean taint.
    exp_t_en[0] = 1'b1; exp_t[0] = 16'h0;
    do_op(0, 8'd7, 8'h0, 8'd13, 8'h0, 0, gp, gt);
    check(0, "u_7x13", gp, 16'h005B);
    check(0, "u_7x13_t", gt, 16'h0000);

    // Single tainted bit on either operand.
    exp_t[0] = 16'h001F;
    do_op(0, 8'd1, 8'h0, 8'd1, 8'h1, 0, gp, gt);
    check(0, "taint_mcnd", gt, 16'h001F);
    check(0, "taint_mcnd_p", gp, 16'h0001);
    do_op(0, 8'd1, 8'h1, 8'd1, 8'h0, 0, gp, gt);
    check(0, "taint_mplr", gt, 16'h001F);

    // Backpressure: ten stalled cycles with in_valid asserted.
    exp_t[0] = 16'h0;
    do_op(0, 8'd9, 8'h0, 8'd11, 8'h0, 10, gp, gt);
    check(0, "bp_9x11", gp, 16'h0063);

    // Signed W=4.
    exp_t_en[1] = 1'b1; exp_t[1] = 16'h0;
    do_op(1, 8'h0D, 8'h0, 8'h05, 8'h0, 0, gp, gt);
    check(1, "s_m3x5", gp, 16'h00F1);
    do_op(1, 8'h08, 8'h0, 8'h08, 8'h0, 0, gp, gt);
    check(1, "s_m8xm8", gp, 16'h0040);

    // Reset in the middle of RUN (count = 2).
    exp_p[0] = 16'h00E1;
    mplr[0] = 8'd15; mcnd[0] = 8'd15; mplr_t[0] = '0; mcnd_t[0] = '0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check(0, "midrun_busy", 16'(busy[0]), 16'(1));
    rst_n = 1'b0;
    #1;
    check(0, "abort_in_ready", 16'(in_ready[0]), 16'(1));
    check(0, "abort_busy", 16'(busy[0]), 16'(0));
    check(0, "abort_out_valid", 16'(out_valid[0]), 16'(0));
    check(0, "abort_product", prod[0], 16'h0);
    check(0, "abort_product_t", prod_t[0], 16'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    do_op(0, 8'd15, 8'h0, 8'd15, 8'h0, 0, gp, gt);
    check(0, "after_reset_15x15", gp, 16'h00E1);

    // Random operands and taints on every configuration.
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 250; i++) begin
        a = 8'($urandom) & wmask(k);
        b = 8'($urandom) & wmask(k);
        if ($urandom_range(0, 3) == 0) begin
          at = 8'h0; bt = 8'h0;
        end else begin
          at = 8'($urandom) & 8'($urandom) & wmask(k);
          bt = 8'($urandom) & 8'($urandom) & wmask(k);
        end
        exp_t_en[k] = (at == 8'h0) && (bt == 8'h0);
        exp_t[k]    = 16'h0;
        do_op(k, a, at, b, bt, int'($urandom_range(0, 2)), gp, gt);
        check(k, "rand_product", gp, model(k, a, b));
        changed = 16'h0;
        for (int j = 0; j < 16; j++) begin
          a2 = a ^ (8'($urandom) & at);
          b2 = b ^ (8'($urandom) & bt);
          changed = changed | (model(k, a2, b2) ^ model(k, a, b));
        end
        check(k, "rand_taint_superset", changed & ~gt, 16'h0);
      end
    end

    n = 0;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global timeout so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected completion before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
